// File: rtl/wb_register_file.sv
// MIPS32 write-back stage: load formatting, source select and a 32x32 register file.
// Define WB_BYPASS_EN to make read ports return the in-flight write-back value.
module wb_register_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_in,
  input  logic [1:0]  MemtoReg_in,
  input  logic [1:0]  MemWidth_in,
  input  logic        SignExtend_Dmemory_in,
  input  logic [31:0] read_data_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] pc_plus_4_in,
  input  logic [4:0]  write_register_address_in,
  input  logic [4:0]  rs_address,
  input  logic [4:0]  rt_address,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] wb_data,
  output logic        wb_write_enable,
  output logic [4:0]  wb_write_address,
  output logic [31:0] write_count
);

  logic [31:0] r_regs [0:31];
  logic [31:0] r_write_count;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;

  always_comb begin
    case (alu_result_in[1:0])
      2'd0:    w_byte = read_data_in[7:0];
      2'd1:    w_byte = read_data_in[15:8];
      2'd2:    w_byte = read_data_in[23:16];
      default: w_byte = read_data_in[31:24];
    endcase
    w_half = alu_result_in[1] ? read_data_in[31:16] : read_data_in[15:0];
  end

  // Halfword lane uses bit 1 only; misaligned halfwords are not trapped here.
  always_comb begin
    case (MemWidth_in)
      2'b01:   w_load = {{16{SignExtend_Dmemory_in & w_half[15]}}, w_half};
      2'b10:   w_load = {{24{SignExtend_Dmemory_in & w_byte[7]}}, w_byte};
      default: w_load = read_data_in;
    endcase
  end

  always_comb begin
    case (MemtoReg_in)
      2'b01:   wb_data = w_load;
      2'b10:   wb_data = pc_plus_4_in;
      default: wb_data = alu_result_in;
    endcase
  end

  assign wb_write_enable  = RegWrite_in && (write_register_address_in != 5'd0);
  assign wb_write_address = write_register_address_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
      r_write_count <= 32'd0;
    end else if (wb_write_enable) begin
      r_regs[write_register_address_in] <= wb_data;
      r_write_count <= r_write_count + 32'd1;
    end
  end

  // Address 0 reads as zero regardless of what the array holds.
  always_comb begin
    w_rs_data = r_regs[rs_address];
    w_rt_data = r_regs[rt_address];
`ifdef WB_BYPASS_EN
    if (wb_write_enable && (rs_address == wb_write_address)) w_rs_data = wb_data;
    if (wb_write_enable && (rt_address == wb_write_address)) w_rt_data = wb_data;
`endif
    if (rs_address == 5'd0) w_rs_data = 32'd0;
    if (rt_address == 5'd0) w_rt_data = 32'd0;
  end

  assign rs_data     = w_rs_data;
  assign rt_data     = w_rt_data;
  assign write_count = r_write_count;

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: load-format table, directed corner
// sequences, then randomized traffic against an array-based reference model.
module tb_wb_register_file;

  logic        clk;
  logic        reset;
  logic        RegWrite_in;
  logic [1:0]  MemtoReg_in;
  logic [1:0]  MemWidth_in;
  logic        SignExtend_Dmemory_in;
  logic [31:0] read_data_in;
  logic [31:0] alu_result_in;
  logic [31:0] pc_plus_4_in;
  logic [4:0]  write_register_address_in;
  logic [4:0]  rs_address;
  logic [4:0]  rt_address;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_write_enable;
  logic [4:0]  wb_write_address;
  logic [31:0] write_count;

  wb_register_file dut (
    .clk(clk), .reset(reset), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .MemWidth_in(MemWidth_in), .SignExtend_Dmemory_in(SignExtend_Dmemory_in),
    .read_data_in(read_data_in), .alu_result_in(alu_result_in), .pc_plus_4_in(pc_plus_4_in),
    .write_register_address_in(write_register_address_in), .rs_address(rs_address),
    .rt_address(rt_address), .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data),
    .wb_write_enable(wb_write_enable), .wb_write_address(wb_write_address),
    .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  memtoreg;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] data;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs[12];

  logic [31:0] m_regs [32];
  logic [31:0] m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 0; RegWrite_in = 0; MemtoReg_in = 0; MemWidth_in = 0;
    SignExtend_Dmemory_in = 0; read_data_in = 0; alu_result_in = 0; pc_plus_4_in = 0;
    write_register_address_in = 0; rs_address = 0; rt_address = 0;
  endtask

  // One full clock: commit on posedge, return at the following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] v);
    idle();
    RegWrite_in = 1; alu_result_in = v; write_register_address_in = a;
    tick();
    idle();
  endtask

  // Reference load formatting written from the lane/extension rules.
  function automatic logic [31:0] m_load(input logic [31:0] d, input logic [31:0] a,
                                         input logic [1:0] w, input logic s);
    longint unsigned v;
    if (w == 2'b10) begin
      v = (longint'(d) >> (8 * (a % 4))) % 256;
      if (s && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (w == 2'b01) begin
      v = (longint'(d) >> (16 * ((a / 2) % 2))) % 65536;
      if (s && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = longint'(d);
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_wb();
    if (MemtoReg_in == 2'b01) return m_load(read_data_in, alu_result_in, MemWidth_in, SignExtend_Dmemory_in);
    if (MemtoReg_in == 2'b10) return pc_plus_4_in;
    return alu_result_in;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [31:0] wbd);
    if (a == 0) return 32'd0;
    if (BYPASS && RegWrite_in && a == write_register_address_in) return wbd;
    return m_regs[a];
  endfunction

  initial begin
    logic [31:0] e_wb;
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      rs_address = 5'(i * 7 + 1); rt_address = 5'(i * 5 + 2);
      #1;
      chk("reset_rs", rs_data, 0);
      chk("reset_rt", rt_data, 0);
    end
    chk("reset_count", write_count, 0);
    $display("txn reset: count=%0d", write_count);

    // Load formatting / source select table.
    vecs[0]  = '{"byte_off3_sext", 2'b01, 2'b10, 1'b1, 32'h80FF7F01, 32'h3, 32'h0, 32'hFFFFFF80};
    vecs[1]  = '{"byte_off3_zext", 2'b01, 2'b10, 1'b0, 32'h80FF7F01, 32'h3, 32'h0, 32'h00000080};
    vecs[2]  = '{"byte_off2_sext", 2'b01, 2'b10, 1'b1, 32'h80FF7F01, 32'h2, 32'h0, 32'hFFFFFFFF};
    vecs[3]  = '{"byte_off0_sext", 2'b01, 2'b10, 1'b1, 32'h80FF7F01, 32'h1000, 32'h0, 32'h00000001};
    vecs[4]  = '{"byte_off1_sext", 2'b01, 2'b10, 1'b1, 32'h80FF7F01, 32'h1, 32'h0, 32'h0000007F};
    vecs[5]  = '{"half_hi_sext",   2'b01, 2'b01, 1'b1, 32'h80FF7F01, 32'h12, 32'h0, 32'hFFFF80FF};
    vecs[6]  = '{"half_bit0_ign",  2'b01, 2'b01, 1'b1, 32'h80FF7F01, 32'h11, 32'h0, 32'h00007F01};
    vecs[7]  = '{"half_hi_zext",   2'b01, 2'b01, 1'b0, 32'h80FF7F01, 32'h2, 32'h0, 32'h000080FF};
    vecs[8]  = '{"word_load",      2'b01, 2'b00, 1'b1, 32'h80FF7F01, 32'h3, 32'h0, 32'h80FF7F01};
    vecs[9]  = '{"width11_word",   2'b01, 2'b11, 1'b1, 32'h80FF7F01, 32'h1, 32'h0, 32'h80FF7F01};
    vecs[10] = '{"sel_alu",        2'b00, 2'b10, 1'b1, 32'h80FF7F01, 32'hCAFE0003, 32'h4, 32'hCAFE0003};
    vecs[11] = '{"sel11_alu",      2'b11, 2'b01, 1'b1, 32'h80FF7F01, 32'h0BAD0002, 32'h4, 32'h0BAD0002};
    foreach (vecs[k]) begin
      idle();
      MemtoReg_in = vecs[k].memtoreg; MemWidth_in = vecs[k].width;
      SignExtend_Dmemory_in = vecs[k].sgn; read_data_in = vecs[k].data;
      alu_result_in = vecs[k].alu; pc_plus_4_in = vecs[k].pc4;
      #1;
      chk(vecs[k].name, wb_data, vecs[k].exp_wb);
      $display("txn %s: wb_data=0x%08h", vecs[k].name, wb_data);
    end
    idle();

    // Preload $5 then reset clears it.
    do_write(5, 32'h12345678);
    rs_address = 5; #1;
    chk("preload_r5", rs_data, 32'h12345678);
    reset = 1; tick(); reset = 0;
    rs_address = 5; #1;
    chk("reset_r5", rs_data, 0);
    chk("reset_cnt2", write_count, 0);
    $display("txn reset_after_preload: r5=0x%08h", rs_data);

    // Link to $31.
    idle();
    RegWrite_in = 1; MemtoReg_in = 2'b10; pc_plus_4_in = 32'h00400010;
    alu_result_in = 32'h1111; write_register_address_in = 31;
    #1;
    chk("link_we", 32'(wb_write_enable), 1);
    chk("link_waddr", 32'(wb_write_address), 31);
    tick(); idle();
    rs_address = 31; #1;
    chk("link_r31", rs_data, 32'h00400010);
    chk("link_cnt", write_count, 1);
    $display("txn link: r31=0x%08h count=%0d", rs_data, write_count);

    // Same write aimed at $0.
    RegWrite_in = 1; MemtoReg_in = 2'b10; pc_plus_4_in = 32'h00400010;
    write_register_address_in = 0;
    #1;
    chk("r0_we", 32'(wb_write_enable), 0);
    tick(); idle();
    rs_address = 0; #1;
    chk("r0_read", rs_data, 0);
    chk("r0_cnt", write_count, 1);
    $display("txn write_r0: r0=0x%08h count=%0d", rs_data, write_count);

    // Same-cycle read of the register being written.
    do_write(8, 32'h00000123);
    RegWrite_in = 1; alu_result_in = 32'hDEADBEEF; write_register_address_in = 8;
    rs_address = 8; rt_address = 8;
    #1;
    chk("same_rs", rs_data, BYPASS ? 32'hDEADBEEF : 32'h00000123);
    chk("same_rt", rt_data, BYPASS ? 32'hDEADBEEF : 32'h00000123);
    tick();
    RegWrite_in = 0; #1;
    chk("next_rs", rs_data, 32'hDEADBEEF);
    chk("next_rt", rt_data, 32'hDEADBEEF);
    $display("txn same_cycle: rs=0x%08h rt=0x%08h", rs_data, rt_data);

    // Reset wins over a same-cycle write.
    do_write(9, 32'h55);
    idle();
    reset = 1; RegWrite_in = 1; alu_result_in = 32'hAA; write_register_address_in = 9;
    tick(); idle();
    rt_address = 9; #1;
    chk("rst_vs_wr_r9", rt_data, 0);
    chk("rst_vs_wr_cnt", write_count, 0);
    $display("txn reset_vs_write: r9=0x%08h count=%0d", rt_data, write_count);

    // Counter wrap.
    force dut.r_write_count = 32'hFFFFFFFF;
    #1;
    release dut.r_write_count;
    chk("wrap_pre", write_count, 32'hFFFFFFFF);
    do_write(3, 32'h77);
    rs_address = 3; #1;
    chk("wrap_cnt", write_count, 0);
    chk("wrap_r3", rs_data, 32'h77);
    $display("txn wrap: count=%0d", write_count);

    // Randomized traffic against the reference model, starting from a clean reset.
    idle(); reset = 1; tick(); reset = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_count = 0;
    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow = ($urandom % 2) == 0;
      reset = ($urandom % 25) == 0;
      RegWrite_in = ($urandom % 4) != 0;
      MemtoReg_in = 2'($urandom);
      MemWidth_in = 2'($urandom);
      SignExtend_Dmemory_in = 1'($urandom);
      read_data_in = $urandom;
      alu_result_in = $urandom;
      pc_plus_4_in = $urandom;
      write_register_address_in = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
      rs_address = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
      rt_address = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
      #1;
      e_wb = m_wb();
      chk("rnd_wb_data", wb_data, e_wb);
      chk("rnd_we", 32'(wb_write_enable), 32'(RegWrite_in && write_register_address_in != 0));
      chk("rnd_rs", rs_data, m_read(rs_address, e_wb));
      chk("rnd_rt", rt_data, m_read(rt_address, e_wb));
      chk("rnd_count", write_count, m_count);
      $display("txn rnd %0d: rst=%0b we=%0b wa=%0d wb=0x%08h cnt=%0d", n, reset, RegWrite_in,
               write_register_address_in, wb_data, write_count);
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_count = 0;
      end else if (RegWrite_in && write_register_address_in != 0) begin
        m_regs[write_register_address_in] = e_wb;
        m_count = m_count + 1;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_register_file.md
# wb_register_file

Write-back stage and architectural register file for the 5-stage MIPS32 pipeline. It consumes the latched outputs of the MEM/WB pipeline register and does three things:
- formats load data by width, byte lane and signedness;
- selects the write-back source;
- commits the result into a 32×32 register file with `$0` hardwired to zero.

It also serves the two ID-stage read ports, exports the committed write for the forwarding unit, and keeps a count of committed writes.

## Interface
- No parameters; widths are fixed by the MIPS32 ISA.
- `clk` input 1 — pipeline clock; all state updates on rising edge.
- `reset` input 1 — synchronous, active-high; one clock with `reset`=1 clears all state.
- `RegWrite_in` input 1 — write-back enable from MEM/WB.
- `MemtoReg_in` input 2 — source select: 00 ALU result, 01 memory load, 10 pc+4 (link), 11 treated as 00.
- `MemWidth_in` input 2 — load width: 00 word, 01 halfword, 10 byte, 11 treated as word.
- `SignExtend_Dmemory_in` input 1 — 1 sign-extends sub-word loads, 0 zero-extends.
- `read_data_in` input 32 — raw aligned data-memory word.
- `alu_result_in` input 32 — ALU result; bits [1:0] are the load byte offset.
- `pc_plus_4_in` input 32 — link value.
- `write_register_address_in` input 5 — destination register.
- `rs_address`, `rt_address` input 5 each — ID-stage read addresses.
- `rs_data`, `rt_data` output 32 each — register read data.
- `wb_data` output 32 — selected write-back value (combinational).
- `wb_write_enable` output 1 — `RegWrite_in` && address != 0.
- `wb_write_address` output 5 — passthrough of `write_register_address_in`.
- `write_count` output 32 — number of committed writes.

## Operation
- **Load formatting:** little-endian lanes.
  - Byte: lane = `alu_result_in[1:0]`, byte n = bits [8n+7:8n].
  - Halfword: lane = `alu_result_in[1]`; bit 0 ignored, no misalignment trap.
  - Word: raw passthrough.
- **Extension:** when `SignExtend_Dmemory_in`=1, replicate bit 7 (byte) or bit 15 (half); otherwise fill with zeros.
- **Source select:** `wb_data` = MUX(`MemtoReg_in`) of formatted load, `alu_result_in`, `pc_plus_4_in`.
- **Commit:** on a rising edge with `wb_write_enable`=1, `regs[write_register_address_in]` <= `wb_data`.
  - Writes to `$0` are discarded.
  - Writes to `$0` do not count.
- **Reads:** combinational. Address 0 always returns 0.
- **Counter:** `write_count` increments by 1 on each committed write and wraps from 0xFFFFFFFF to 0.
- **Reset:**
  - All 32 registers and `write_count` become 0.
  - Reset has priority over a same-cycle write; that write is lost and not counted.
  - Reset asserted mid-stream is applied identically; after release, the first commit takes place on the next enabled edge.
- **Reset values of outputs:**
  - `rs_data` and `rt_data` are 0 (all registers are 0).
  - `write_count` is 0.
  - `wb_data`, `wb_write_enable` and `wb_write_address` are combinational from the inputs, with no stored state.

## Timing
- `wb_data` and `wb_write_enable` settle combinationally within the WB cycle.
- A write is architecturally visible from the cycle after the commit edge (1-cycle write latency).
- A same-cycle read of the address being written returns the old value unless the bypass is enabled (see Configuration).
- Both read ports may read the same register as each other and as the write target in the same cycle.
- `write_count` updates on the same edge as the register write.

## Configuration
- `WB_BYPASS_EN` defined:
  - If `wb_write_enable`=1 and `rs_address` (or `rt_address`) equals `wb_write_address` and is nonzero, that port returns `wb_data` in the same cycle (write-through).
  - This removes the separate WB→ID forwarding path.
- `WB_BYPASS_EN` undefined:
  - Ports return stored contents only.
  - The hazard unit must stall or forward one extra cycle.

## Test plan
- **Reset:** assert `reset` 1 cycle after preloading `$5`=0x12345678 → `rs_data`(`$5`)=0 and `write_count`=0 on the next cycle.
- **Byte load:** `read_data_in`=0x80FF7F01, `MemtoReg`=01, `MemWidth`=10, offset=3, sign=1 → `wb_data`=0xFFFFFF80. With sign=0 → 0x00000080. Offset=2, sign=1 → 0xFFFFFFFF.
- **Halfword load:** same data, `MemWidth`=01, `alu_result_in`=0x...2, sign=1 → 0xFFFF80FF. `alu_result_in`=0x...1 → 0x00007F01 (bit 0 ignored).
- **Link and `$0`:**
  - `MemtoReg`=10, `pc_plus_4_in`=0x00400010, dest `$31`, `RegWrite`=1 → `$31`=0x00400010 next cycle, `write_count`+1.
  - Same with dest `$0` → `$0` reads 0, count unchanged.
- **Same-cycle read/write:** write 0xDEADBEEF to `$8` while `rs_address`=`rt_address`=8 → 0xDEADBEEF that cycle with `WB_BYPASS_EN`, old value without it. Both builds show 0xDEADBEEF the next cycle.
- **Reset vs write and counter wrap:**
  - `reset`=1 with a valid write to `$9` → `$9`=0, count=0.
  - Preload `write_count`=0xFFFFFFFF via a bench force, then commit one write → `write_count`=0.
